// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: opcodes, ALUOp codes,
// sequencer state encoding and opcode classification.
package cpu_pkg;

    localparam logic [3:0] OP_RLOG = 4'b0000;
    localparam logic [3:0] OP_RADD = 4'b0001;
    localparam logic [3:0] OP_RSH  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUBI = 4'b1010;
    localparam logic [3:0] OP_SLTI = 4'b1011;
    localparam logic [3:0] OP_LW   = 4'b1100;
    localparam logic [3:0] OP_SW   = 4'b1101;
    localparam logic [3:0] OP_BEQ  = 4'b1111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        C_R   = 3'd0,
        C_I   = 3'd1,
        C_LW  = 3'd2,
        C_SW  = 3'd3,
        C_BEQ = 3'd4,
        C_ILL = 3'd5
    } op_class_e;

    function automatic op_class_e classify(input logic [3:0] op);
        op_class_e cls;
        case (op)
            OP_RLOG, OP_RADD, OP_RSH: cls = C_R;
            OP_ADDI, OP_SUBI, OP_SLTI: cls = C_I;
            OP_LW:                     cls = C_LW;
            OP_SW:                     cls = C_SW;
            OP_BEQ:                    cls = C_BEQ;
            default:                   cls = C_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle Moore control sequencer: steps the shared datapath one phase per
// cycle with request/ready handshakes to instruction and data memory.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic [3:0]       opcode_i,
    input  logic             zero_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    output logic             imem_req_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic             reg_dst_o,
    output logic             alu_src_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [1:0]       alu_op_o,
    output logic             illegal_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] retire_count_o
);

    state_e             state_q, state_d;
    logic               is_r_q, is_r_d;
    logic               is_lw_q, is_lw_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   retire_q;
    logic               retire_s;
    logic [1:0]         rst_sync_q;
    logic               rst_int_n;
    op_class_e          cls_s;
    logic               unused_zero_s;

    // Zero only qualifies PCWriteCond inside the datapath.
    assign unused_zero_s = zero_i;
    assign cls_s         = classify(opcode_i);
    assign rst_int_n     = rst_sync_q[1];

    // Reset synchronizer: asserts immediately, releases two clocks later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    // State, stored class bits, sticky illegal flag and retire counter.
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= S_IDLE;
            is_r_q    <= 1'b0;
            is_lw_q   <= 1'b0;
            illegal_q <= 1'b0;
            retire_q  <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            is_r_q    <= is_r_d;
            is_lw_q   <= is_lw_d;
            illegal_q <= illegal_d;
            if (retire_s) begin
                retire_q <= retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retire_q <= retire_q;
            end
        end
    end

    // Next-state selection and retire detection.
    always_comb begin
        state_d   = state_q;
        is_r_d    = is_r_q;
        is_lw_d   = is_lw_q;
        illegal_d = illegal_q;
        retire_s  = 1'b0;
        case (state_q)
            S_IDLE:   state_d = run_i ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = imem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                is_r_d  = (cls_s == C_R);
                is_lw_d = (cls_s == C_LW);
                case (cls_s)
                    C_R:        state_d = S_EXEC_R;
                    C_I:        state_d = S_EXEC_I;
                    C_LW, C_SW: state_d = S_ADDR;
                    C_BEQ:      state_d = S_BRANCH;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = run_i ? S_FETCH : S_IDLE;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_ADDR:   state_d = is_lw_q ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_d = dmem_ready_i ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: begin
                if (dmem_ready_i) begin
                    retire_s = 1'b1;
                    state_d  = run_i ? S_FETCH : S_IDLE;
                end else begin
                    state_d  = S_MEM_WR;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: begin
                retire_s = 1'b1;
                state_d  = run_i ? S_FETCH : S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Control decode; only the fetch write strobes look at a ready input.
    always_comb begin
        imem_req_o      = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        reg_dst_o       = 1'b0;
        alu_src_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        alu_op_o        = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                ir_write_o = imem_ready_i;
                pc_write_o = imem_ready_i;
            end
            S_EXEC_R: begin
                reg_dst_o = 1'b1;
                alu_op_o  = ALU_RTYPE;
            end
            S_EXEC_I: begin
                alu_src_o = 1'b1;
                alu_op_o  = ALU_ITYPE;
            end
            S_WB_ALU: begin
                reg_write_o = 1'b1;
                reg_dst_o   = is_r_q;
                alu_src_o   = ~is_r_q;
                alu_op_o    = is_r_q ? ALU_RTYPE : ALU_ITYPE;
            end
            S_ADDR:   alu_src_o = 1'b1;
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                alu_src_o  = 1'b1;
            end
            S_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEM_WR: mem_write_o = 1'b1;
            S_BRANCH: begin
                pc_write_cond_o = 1'b1;
                alu_op_o        = ALU_SUB;
            end
            default: begin
                imem_req_o = 1'b0;
            end
        endcase
    end

    assign busy_o         = (state_q != S_IDLE);
    assign illegal_o      = illegal_q;
    assign retire_count_o = retire_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed plus randomized bench for cpu_sequencer against an instruction-level
// model of per-cycle control vectors, retire count and sticky illegal flag.
module tb_cpu_sequencer;

    localparam int CW = 4;

    // {imem_req, ir_write, pc_write, pc_write_cond, reg_dst, alu_src,
    //  mem_to_reg, reg_write, mem_read, mem_write, alu_op[1:0], busy}
    localparam logic [12:0] V_IDLE  = 13'b0_0_0_0_0_0_0_0_0_0_00_0;
    localparam logic [12:0] V_FWAIT = 13'b1_0_0_0_0_0_0_0_0_0_00_1;
    localparam logic [12:0] V_FGO   = 13'b1_1_1_0_0_0_0_0_0_0_00_1;
    localparam logic [12:0] V_DEC   = 13'b0_0_0_0_0_0_0_0_0_0_00_1;
    localparam logic [12:0] V_EXR   = 13'b0_0_0_0_1_0_0_0_0_0_10_1;
    localparam logic [12:0] V_EXI   = 13'b0_0_0_0_0_1_0_0_0_0_11_1;
    localparam logic [12:0] V_WBR   = 13'b0_0_0_0_1_0_0_1_0_0_10_1;
    localparam logic [12:0] V_WBI   = 13'b0_0_0_0_0_1_0_1_0_0_11_1;
    localparam logic [12:0] V_ADDR  = 13'b0_0_0_0_0_1_0_0_0_0_00_1;
    localparam logic [12:0] V_MRD   = 13'b0_0_0_0_0_1_0_0_1_0_00_1;
    localparam logic [12:0] V_WBM   = 13'b0_0_0_0_0_0_1_1_0_0_00_1;
    localparam logic [12:0] V_MWR   = 13'b0_0_0_0_0_0_0_0_0_1_00_1;
    localparam logic [12:0] V_BR    = 13'b0_0_0_1_0_0_0_0_0_0_01_1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [3:0]    opcode = 4'd0;
    logic          zero = 1'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, ir_write, pc_write, pc_write_cond;
    logic          reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
    logic [1:0]    alu_op;
    logic          illegal, busy;
    logic [CW-1:0] retire_count;
    logic [12:0]   obs;

    int total = 0;
    int bad = 0;
    int cnt_m = 0;
    bit ill_m = 1'b0;
    bit in_idle = 1'b1;

    cpu_sequencer #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run), .opcode_i(opcode),
        .zero_i(zero), .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
        .imem_req_o(imem_req), .ir_write_o(ir_write), .pc_write_o(pc_write),
        .pc_write_cond_o(pc_write_cond), .reg_dst_o(reg_dst), .alu_src_o(alu_src),
        .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .alu_op_o(alu_op), .illegal_o(illegal),
        .busy_o(busy), .retire_count_o(retire_count)
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, ir_write, pc_write, pc_write_cond, reg_dst, alu_src,
                  mem_to_reg, reg_write, mem_read, mem_write, alu_op, busy};

    task automatic check_cycle(input logic [12:0] exp_v, input string tag);
        logic [CW-1:0] exp_cnt;
        exp_cnt = CW'(cnt_m);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s ctrl got=%b exp=%b", tag, obs, exp_v);
        end
        total++;
        assert (retire_count === exp_cnt) else begin
            bad++;
            $error("FAIL %s retire got=%0d exp=%0d", tag, retire_count, exp_cnt);
        end
        total++;
        assert (illegal === ill_m) else begin
            bad++;
            $error("FAIL %s illegal got=%b exp=%b", tag, illegal, ill_m);
        end
    endtask

    task automatic idle_cycle(input bit run_v, input string tag);
        @(negedge clk);
        run        = run_v;
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        opcode     = 4'($urandom);
        zero       = 1'($urandom);
        #1 check_cycle(V_IDLE, tag);
        in_idle = !run_v;
    endtask

    // Executes one instruction: wi fetch wait cycles, wd data wait cycles.
    task automatic run_instr(input logic [3:0] op, input int wi, input int wd,
                             input bit run_after, input string tag);
        logic [12:0] exp_q[$];
        int mem_start;
        int n;
        bit legal;
        if (in_idle) idle_cycle(1'b1, {tag, "_start"});
        mem_start = -1;
        legal = 1'b1;
        for (int i = 0; i < wi; i++) exp_q.push_back(V_FWAIT);
        exp_q.push_back(V_FGO);
        exp_q.push_back(V_DEC);
        case (op)
            4'b0000, 4'b0001, 4'b0010: begin
                exp_q.push_back(V_EXR);
                exp_q.push_back(V_WBR);
            end
            4'b1001, 4'b1010, 4'b1011: begin
                exp_q.push_back(V_EXI);
                exp_q.push_back(V_WBI);
            end
            4'b1100: begin
                exp_q.push_back(V_ADDR);
                mem_start = exp_q.size();
                for (int i = 0; i <= wd; i++) exp_q.push_back(V_MRD);
                exp_q.push_back(V_WBM);
            end
            4'b1101: begin
                exp_q.push_back(V_ADDR);
                mem_start = exp_q.size();
                for (int i = 0; i <= wd; i++) exp_q.push_back(V_MWR);
            end
            4'b1111: exp_q.push_back(V_BR);
            default: legal = 1'b0;
        endcase
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            opcode     = (c <= wi) ? 4'($urandom) : op;
            imem_ready = (c < wi) ? 1'b0 : ((c == wi) ? 1'b1 : 1'($urandom));
            if (mem_start >= 0 && c >= mem_start && c <= mem_start + wd)
                dmem_ready = (c == mem_start + wd);
            else
                dmem_ready = 1'($urandom);
            zero = 1'($urandom);
            run  = (c == n - 1) ? run_after : 1'($urandom);
            #1 check_cycle(exp_q[c], tag);
            if (!legal && c == wi + 1) ill_m = 1'b1;
            if (legal && c == n - 1) cnt_m = (cnt_m + 1) % (1 << CW);
        end
        in_idle = 1'b0;
        if (!run_after) idle_cycle(1'b0, {tag, "_idle"});
    endtask

    initial begin
        // Power-on reset held for a few cycles, then release.
        #2 check_cycle(V_IDLE, "reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle_cycle(1'b0, "post_reset");

        run_instr(4'b0001, 0, 0, 1'b1, "add");
        run_instr(4'b1100, 0, 3, 1'b1, "lw_wait3");
        run_instr(4'b1111, 0, 0, 1'b1, "beq_a");
        run_instr(4'b1111, 0, 0, 1'b1, "beq_b");
        run_instr(4'b0101, 0, 0, 1'b1, "illegal");
        run_instr(4'b0000, 2, 0, 1'b1, "and_fwait");
        run_instr(4'b1101, 0, 2, 1'b0, "sw_stop");
        run_instr(4'b1001, 0, 0, 1'b1, "addi");
        run_instr(4'b1100, 1, 0, 1'b1, "lw_nowait");

        for (int k = 0; k < 40; k++)
            run_instr(4'($urandom_range(0, 15)), $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0), "rand");

        // Asynchronous reset during a fetch wait.
        if (in_idle) idle_cycle(1'b1, "rst_start");
        @(negedge clk);
        imem_ready = 1'b0;
        run        = 1'b1;
        #1 check_cycle(V_FWAIT, "rst_fwait");
        rst_n = 1'b0;
        cnt_m = 0;
        ill_m = 1'b0;
        #1 check_cycle(V_IDLE, "rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle_cycle(1'b0, "rst_release");
        run_instr(4'b1010, 1, 0, 1'b0, "subi_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
